tcb_lib_misalign_split: RTL and testbench
=========================================

// Module: tcb_lib_misalign_split
// PURPOSE
//  Request-side stage placed directly upstream of a byte-enable TCB subordinate (e.g. the VIP memory).
//  Accepts log-size requests at any byte alignment. Issues aligned byte-enable requests downstream.
//  A request crossing a bus-word boundary is split into two aligned beats; their read data is merged back.
//  Fixed response delay is preserved relative to the upstream transfer.
// PARAMETERS
//  AW   32  address width
//  DW   32  data width; BEN = DW/8 byte lanes, power of 2
//  DLY  1   downstream response delay in cycles (>=1); upstream response delay is identical
// PORTS
//  clk      in   1               clock
//  rst      in   1               synchronous active-high reset
//  sub_vld  in   1               upstream request valid
//  sub_rdy  out  1               upstream ready; upstream transfer = sub_vld & sub_rdy
//  sub_wen  in   1               write enable
//  sub_adr  in   AW              byte address, any alignment
//  sub_siz  in   $clog2($clog2(BEN)+1)  log2 of transfer size in bytes
//  sub_wdt  in   DW              write data, LSB-aligned (byte b -> adr+b)
//  sub_rdt  out  DW              read data, LSB-aligned
//  sub_sts  out  1               response error status
//  man_vld  out  1               downstream request valid
//  man_rdy  in   1               downstream ready
//  man_wen  out  1               write enable
//  man_adr  out  AW              aligned address (low $clog2(BEN) bits zero)
//  man_ben  out  BEN             byte enables, lane-indexed
//  man_wdt  out  DW              write data in byte lanes
//  man_rdt  in   DW              read data in byte lanes, DLY cycles after transfer
//  man_sts  in   1               downstream status
//  spl_cnt  out  32              split counter (TCB_SPLIT_CNT_EN only)
// BEHAVIOUR
//  - off = sub_adr%BEN, n = 2**sub_siz; split = (off+n > BEN).
//  - Lane mapping: upstream byte b uses lane (off+b)%BEN. Beat1 enables lanes off..min(off+n,BEN)-1.
//  - Beat2 (split only) uses man_adr = aligned(sub_adr)+BEN, wrapping modulo 2**AW. It enables lanes 0..off+n-BEN-1.
//  - FSM IDLE/BEAT2. IDLE, not split: man_* = beat1, man_vld = sub_vld, sub_rdy = man_rdy; combinational, zero added latency.
//  - IDLE, split: drive beat1, sub_rdy=0; on man_rdy -> BEAT2.
//  - BEAT2: drive beat2 from held upstream request (upstream holds vld and payload stable while rdy=0).
//    sub_rdy = man_rdy; on man_rdy -> IDLE.
//  - Downstream stall (man_rdy=0) in either state: hold state and outputs; no request dropped or duplicated.
//  - Response tracker: DLY-deep shift register of {valid, is_beat1, off, siz}, written on every man transfer.
//  - When a beat1 entry exits, man_rdt/man_sts are captured in a hold register.
//    One register suffices because the next beat1 response cannot arrive before the merge.
//  - When a final (non-beat1) entry exits, drive sub_rdt/sub_sts that cycle:
//    byte b = hold lane off+b if off+b<BEN, else man_rdt lane (off+b)%BEN; sub_sts = man_sts | hold_sts (split).
//    Bytes b>=n are 0.
//  - Writes produce responses too (sts only; sub_rdt = 0). With no response exiting, sub_rdt=0 and sub_sts=0.
//  - Reset: state IDLE, tracker cleared, hold regs 0. While rst: man_vld=0, sub_rdy=0, sub_rdt=0, sub_sts=0.
//  - Reset mid-split: beat2 is never issued and in-flight responses are discarded. Upstream must reissue.
// CONFIGURATION
//  TCB_SPLIT_CNT_EN defined:
//    spl_cnt exists; it increments by 1 on each accepted beat1 of a split request, wraps at 2**32, reset 0.
//  Undefined: no spl_cnt port and no counter logic; all other behaviour is identical.
// TESTING (AW=32, DW=32, DLY=1, VIP memory downstream)
//  1 aligned write adr=0x10 siz=2 wdt=0x44332211 -> one beat adr=0x10 ben=1111, sub_rdy=1 same cycle.
//  2 read adr=0x13 siz=2, mem[0x13..0x16]=AA BB CC DD -> beats 0x10/1000 then 0x14/0111.
//    sub_rdy high on beat2 only; sub_rdt=0xDDCCBBAA one cycle later.
//  3 write adr=0x0F siz=1 wdt=0x2211 -> beat 0x0C ben=1000 lane3=0x11, then 0x10 ben=0001 lane0=0x22.
//  4 case 2 with man_rdy=0 for 2 cycles before beat2, then an immediate back-to-back aligned read.
//    -> both merged correctly, no duplicate beats; beat1 man_sts=1 gives sub_sts=1.
//  5 read adr=0xFFFFFFFF siz=1 -> beat1 0xFFFFFFFC ben=1000, beat2 0x00000000 ben=0001.
//  6 rst pulsed while in BEAT2 -> IDLE next cycle, beat2 not issued, sub_rdt=0, sub_sts=0.
//    spl_cnt=0 (macro on).

Source files
------------

// File: rtl/tcb_lib_misalign_split.sv
`default_nettype none
//==============================================================================
// Module : tcb_lib_misalign_split
// Brief  : Request-side TCB stage that turns arbitrarily aligned log-size
//          requests into aligned byte-enable beats. A request that crosses a
//          bus-word boundary is issued as two beats and its read data is
//          merged back, keeping the fixed response delay of the upstream
//          transfer.
// Config : define TCB_SPLIT_CNT_EN to add the spl_cnt split counter port.
// Rev    : 1.0 - initial release
//==============================================================================
module tcb_lib_misalign_split #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned DLY = 1
)(
  input  logic                                 clk,
  input  logic                                 rst,
  // upstream (subordinate side of this stage)
  input  logic                                 sub_vld,
  output logic                                 sub_rdy,
  input  logic                                 sub_wen,
  input  logic [AW-1:0]                        sub_adr,
  input  logic [$clog2($clog2(DW/8)+1)-1:0]    sub_siz,
  input  logic [DW-1:0]                        sub_wdt,
  output logic [DW-1:0]                        sub_rdt,
  output logic                                 sub_sts,
  // downstream (manager side of this stage)
  output logic                                 man_vld,
  input  logic                                 man_rdy,
  output logic                                 man_wen,
  output logic [AW-1:0]                        man_adr,
  output logic [DW/8-1:0]                      man_ben,
  output logic [DW-1:0]                        man_wdt,
  input  logic [DW-1:0]                        man_rdt,
  input  logic                                 man_sts
`ifdef TCB_SPLIT_CNT_EN
  ,
  output logic [31:0]                          spl_cnt
`endif
);

  localparam int unsigned BEN = DW/8;
  localparam int unsigned OW  = $clog2(BEN);
  localparam int unsigned SW  = $clog2(OW+1);

  // byte-lane count, wide enough to compare against off+n without overflow
  localparam logic [OW+1:0] c_ben = (OW+2)'(BEN);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BEAT2 = 1'b1
  } state_t;

  // response tracker entry: one per downstream transfer
  typedef struct packed {
    logic          vld;
    logic          b1;   // first beat of a split request
    logic          wen;
    logic [OW-1:0] off;
    logic [SW-1:0] siz;
  } trk_t;

  // lane arithmetic wraps modulo BEN by truncation to OW bits
  function automatic logic [OW-1:0] lane_add(input logic [OW-1:0] a, input logic [OW-1:0] b);
    return a + b;
  endfunction

  function automatic logic [OW-1:0] lane_sub(input logic [OW-1:0] a, input logic [OW-1:0] b);
    return a - b;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;

  logic [OW-1:0]   w_off;
  logic [OW+1:0]   w_n;
  logic [OW+1:0]   w_end;
  logic            w_split;
  logic [AW-1:0]   w_adr_al;
  logic [BEN-1:0]  w_ben1;
  logic [BEN-1:0]  w_ben2;
  logic            w_is_b1;
  logic            w_man_trn;

  trk_t            r_trk [DLY];
  trk_t            w_trk_in;
  trk_t            w_exit;
  logic [DW-1:0]   r_hold_rdt;
  logic            r_hold_sts;
  logic [OW+1:0]   w_rsp_n;
  logic            w_rsp_split;

  // request geometry: offset, size, boundary crossing and aligned base
  always_comb begin
    w_off    = sub_adr[OW-1:0];
    w_n      = (OW+2)'(1) << sub_siz;
    w_end    = (OW+2)'(w_off) + w_n;
    w_split  = (w_end > c_ben);
    w_adr_al = {sub_adr[AW-1:OW], {OW{1'b0}}};
  end

  // byte enables of both beats and lane-rotated write data (same for both beats)
  always_comb begin
    w_ben1  = '0;
    w_ben2  = '0;
    man_wdt = '0;
    for (int l = 0; l < BEN; l++) begin
      w_ben1[l] = ((OW+2)'(l) >= (OW+2)'(w_off)) && ((OW+2)'(l) < w_end);
      w_ben2[l] = (((OW+2)'(l) + c_ben) < w_end);
      man_wdt[8*l +: 8] = sub_wdt[8*lane_sub(OW'(l), w_off) +: 8];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state and request-side handshake; reset forces both sides idle
  always_comb begin
    w_state_nxt = r_state;
    man_vld     = 1'b0;
    sub_rdy     = 1'b0;
    man_adr     = w_adr_al;
    man_ben     = w_ben1;
    w_is_b1     = 1'b0;
    case (r_state)
      S_IDLE: begin
        man_vld = sub_vld;
        if (w_split) begin
          w_is_b1 = 1'b1;
          if (sub_vld && man_rdy) w_state_nxt = S_BEAT2;
        end else begin
          sub_rdy = man_rdy;
        end
      end
      S_BEAT2: begin
        // upstream keeps the request stable until sub_rdy, so beat2 is
        // rebuilt from the live inputs instead of a stored copy
        man_vld = 1'b1;
        man_adr = w_adr_al + AW'(BEN);
        man_ben = w_ben2;
        sub_rdy = man_rdy;
        if (man_rdy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      man_vld = 1'b0;
      sub_rdy = 1'b0;
    end
  end

  assign man_wen   = sub_wen;
  assign w_man_trn = man_vld & man_rdy;

  // tracker entry describing the beat being transferred this cycle
  always_comb begin
    w_trk_in     = '0;
    w_trk_in.vld = w_man_trn;
    w_trk_in.b1  = w_is_b1;
    w_trk_in.wen = sub_wen;
    w_trk_in.off = w_off;
    w_trk_in.siz = sub_siz;
  end

  // response tracker: DLY-deep shift register aligned with downstream latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) r_trk[i] <= '0;
    end else begin
      r_trk[0] <= w_trk_in;
      for (int i = 1; i < DLY; i++) r_trk[i] <= r_trk[i-1];
    end
  end

  assign w_exit = r_trk[DLY-1];

  // capture the first-beat response of a split until the second one arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_rdt <= '0;
      r_hold_sts <= 1'b0;
    end else if (w_exit.vld && w_exit.b1) begin
      r_hold_rdt <= man_rdt;
      r_hold_sts <= man_sts;
    end
  end

  // merge held and live lanes into LSB-aligned upstream read data
  always_comb begin
    w_rsp_n     = (OW+2)'(1) << w_exit.siz;
    w_rsp_split = (((OW+2)'(w_exit.off) + w_rsp_n) > c_ben);
    sub_rdt     = '0;
    sub_sts     = 1'b0;
    if (!rst && w_exit.vld && !w_exit.b1) begin
      sub_sts = man_sts | (w_rsp_split & r_hold_sts);
      if (!w_exit.wen) begin
        for (int b = 0; b < BEN; b++) begin
          if ((OW+2)'(b) < w_rsp_n) begin
            if (w_rsp_split && (((OW+2)'(b) + (OW+2)'(w_exit.off)) < c_ben))
              sub_rdt[8*b +: 8] = r_hold_rdt[8*lane_add(OW'(b), w_exit.off) +: 8];
            else
              sub_rdt[8*b +: 8] = man_rdt[8*lane_add(OW'(b), w_exit.off) +: 8];
          end
        end
      end
    end
  end

`ifdef TCB_SPLIT_CNT_EN
  logic [31:0] r_spl_cnt;

  // count accepted first beats of split requests
  always_ff @(posedge clk) begin
    if (rst)                       r_spl_cnt <= '0;
    else if (w_man_trn && w_is_b1) r_spl_cnt <= r_spl_cnt + 32'd1;
  end

  assign spl_cnt = r_spl_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcb_lib_misalign_split.sv
`default_nettype none
//==============================================================================
// Module : tb_tcb_lib_misalign_split
// Brief  : Scoreboard bench for tcb_lib_misalign_split with a byte-enable
//          memory model downstream (DLY=1). TCB_SPLIT_CNT_EN adds spl_cnt checks.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_tcb_lib_misalign_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        sub_vld = 1'b0;
  logic        sub_rdy;
  logic        sub_wen = 1'b0;
  logic [31:0] sub_adr = 32'h0;
  logic [1:0]  sub_siz = 2'd0;
  logic [31:0] sub_wdt = 32'h0;
  logic [31:0] sub_rdt;
  logic        sub_sts;
  logic        man_vld;
  logic        man_rdy = 1'b1;
  logic        man_wen;
  logic [31:0] man_adr;
  logic [3:0]  man_ben;
  logic [31:0] man_wdt;
  logic [31:0] man_rdt = 32'h0;
  logic        man_sts = 1'b0;
`ifdef TCB_SPLIT_CNT_EN
  logic [31:0] spl_cnt;
  logic [31:0] cnt_exp = 32'h0;
  logic        cnt_chk = 1'b0;
`endif

  tcb_lib_misalign_split #(.AW(32), .DW(32), .DLY(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .sub_vld (sub_vld),
    .sub_rdy (sub_rdy),
    .sub_wen (sub_wen),
    .sub_adr (sub_adr),
    .sub_siz (sub_siz),
    .sub_wdt (sub_wdt),
    .sub_rdt (sub_rdt),
    .sub_sts (sub_sts),
    .man_vld (man_vld),
    .man_rdy (man_rdy),
    .man_wen (man_wen),
    .man_adr (man_adr),
    .man_ben (man_ben),
    .man_wdt (man_wdt),
    .man_rdt (man_rdt),
    .man_sts (man_sts)
`ifdef TCB_SPLIT_CNT_EN
    ,
    .spl_cnt (spl_cnt)
`endif
  );

  // byte-enable memory model, response one cycle after the transfer
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  logic       err_flag  = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
      mem[8'h13] <= 8'hAA; mem[8'h14] <= 8'hBB;
      mem[8'h15] <= 8'hCC; mem[8'h16] <= 8'hDD;
      mem[8'hFF] <= 8'h5A; mem[8'h00] <= 8'hA5;
      mem_ready  <= 1'b1;
    end else if (!rst && man_vld && man_rdy) begin
      for (int l = 0; l < 4; l++) begin
        if (man_wen && man_ben[l]) mem[8'(man_adr[7:0] + l)] <= man_wdt[8*l +: 8];
        man_rdt[8*l +: 8] <= man_wen ? 8'h00 : mem[8'(man_adr[7:0] + l)];
      end
      man_sts <= err_flag;
    end
  end

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  ben;
    logic        wen;
    logic [31:0] wdt;
    logic        rdy;
  } beat_t;

  typedef struct {
    logic [31:0] rdt;
    logic        sts;
  } rsp_t;

  beat_t exp_beats [$];
  rsp_t  exp_rsps  [$];

  int    checks   = 0;
  int    failures = 0;
  int    tmo_cnt  = 0;
  int    cyc      = 0;
  bit    done     = 1'b0;
  bit    resp_due = 1'b0;
  beat_t mb;
  rsp_t  mr;
  logic [31:0] wmask;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // monitor: compares every DUT beat and response against the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cmp("rst_man_vld", {31'b0, man_vld}, 32'h0);
      cmp("rst_sub_rdy", {31'b0, sub_rdy}, 32'h0);
      cmp("rst_sub_rdt", sub_rdt, 32'h0);
      cmp("rst_sub_sts", {31'b0, sub_sts}, 32'h0);
      resp_due = 1'b0;
    end else begin
      if (resp_due) begin
        if (exp_rsps.size() == 0) begin
          cmp("rsp_unexpected", 32'h1, 32'h0);
        end else begin
          mr = exp_rsps.pop_front();
          cmp("rsp_rdt", sub_rdt, mr.rdt);
          cmp("rsp_sts", {31'b0, sub_sts}, {31'b0, mr.sts});
        end
      end else begin
        cmp("rsp_idle", {sub_rdt[31:1], sub_rdt[0] | sub_sts}, 32'h0);
      end
      if (man_vld && man_rdy) begin
        if (exp_beats.size() == 0) begin
          cmp("beat_unexpected", man_adr, 32'hFFFF_FFFF);
        end else begin
          mb = exp_beats.pop_front();
          for (int l = 0; l < 4; l++) wmask[8*l +: 8] = {8{mb.ben[l] & mb.wen}};
          cmp("beat_adr", man_adr, mb.adr);
          cmp("beat_ben", {28'b0, man_ben}, {28'b0, mb.ben});
          cmp("beat_wen_rdy", {30'b0, man_wen, sub_rdy}, {30'b0, mb.wen, mb.rdy});
          cmp("beat_wdt", man_wdt & wmask, mb.wdt & wmask);
        end
      end
      resp_due = sub_vld && sub_rdy;
    end
`ifdef TCB_SPLIT_CNT_EN
    if (cnt_chk) cmp("spl_cnt", spl_cnt, cnt_exp);
`endif
    if (done) begin
      cmp("beats_left", exp_beats.size(), 32'h0);
      cmp("rsps_left", exp_rsps.size(), 32'h0);
      cmp("timeouts", tmo_cnt, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (cyc > 3000) begin
      failures++;
      $display("FAIL watchdog actual=%0d required<=3000", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic push_beat(input logic [31:0] adr, input logic [3:0] ben, input logic wen,
                           input logic [31:0] wdt, input logic rdy);
    beat_t b;
    b.adr = adr; b.ben = ben; b.wen = wen; b.wdt = wdt; b.rdy = rdy;
    exp_beats.push_back(b);
  endtask

  task automatic push_rsp(input logic [31:0] rdt, input logic sts);
    rsp_t r;
    r.rdt = rdt; r.sts = sts;
    exp_rsps.push_back(r);
  endtask

  task automatic drive(input logic wen, input logic [31:0] adr, input logic [1:0] siz,
                       input logic [31:0] wdt);
    sub_vld = 1'b1; sub_wen = wen; sub_adr = adr; sub_siz = siz; sub_wdt = wdt;
  endtask

  // hold the request until accepted (bounded), then drop valid
  task automatic wait_acc();
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (sub_rdy) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) tmo_cnt++;
    @(posedge clk); #1;
    sub_vld = 1'b0;
  endtask

  task automatic issue(input logic wen, input logic [31:0] adr, input logic [1:0] siz,
                       input logic [31:0] wdt);
    drive(wen, adr, siz, wdt);
    wait_acc();
  endtask

  initial begin
    // reset with a pending request: nothing may leak out
    drive(1'b0, 32'h10, 2'd2, 32'h0);
`ifdef TCB_SPLIT_CNT_EN
    cnt_exp = 32'd0; cnt_chk = 1'b1;
`endif
    repeat (3) @(posedge clk); #1;
    rst = 1'b0; sub_vld = 1'b0;
`ifdef TCB_SPLIT_CNT_EN
    cnt_chk = 1'b0;
`endif
    @(posedge clk); #1;

    // split read 0x13: AA BB CC DD
    push_beat(32'h10, 4'b1000, 1'b0, 32'h0, 1'b0);
    push_beat(32'h14, 4'b0111, 1'b0, 32'h0, 1'b1);
    push_rsp(32'hDDCCBBAA, 1'b0);
    issue(1'b0, 32'h13, 2'd2, 32'h0);

    // aligned word write
    push_beat(32'h10, 4'b1111, 1'b1, 32'h44332211, 1'b1);
    push_rsp(32'h0, 1'b0);
    issue(1'b1, 32'h10, 2'd2, 32'h44332211);

    // split halfword write 0x0F: 0x11 -> 0x0F lane3, 0x22 -> 0x10 lane0
    push_beat(32'h0C, 4'b1000, 1'b1, 32'h11000000, 1'b0);
    push_beat(32'h10, 4'b0001, 1'b1, 32'h00000022, 1'b1);
    push_rsp(32'h0, 1'b0);
    issue(1'b1, 32'h0F, 2'd1, 32'h00002211);

    // split read with beat1 error and a 2-cycle stall before beat2
    push_beat(32'h10, 4'b1000, 1'b0, 32'h0, 1'b0);
    push_beat(32'h14, 4'b0111, 1'b0, 32'h0, 1'b1);
    push_rsp(32'hDDCCBB44, 1'b1);
    drive(1'b0, 32'h13, 2'd2, 32'h0);
    err_flag = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    err_flag = 1'b0; man_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;
    man_rdy = 1'b1;
    wait_acc();
    // back-to-back aligned read: 22 22 33 44
    push_beat(32'h10, 4'b1111, 1'b0, 32'h0, 1'b1);
    push_rsp(32'h44332222, 1'b0);
    issue(1'b0, 32'h10, 2'd2, 32'h0);

    // split across the top of the address space
    push_beat(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0, 1'b0);
    push_beat(32'h00000000, 4'b0001, 1'b0, 32'h0, 1'b1);
    push_rsp(32'h0000A55A, 1'b0);
    issue(1'b0, 32'hFFFFFFFF, 2'd1, 32'h0);

    // unaligned single byte, and halfword ending exactly on the word edge
    push_beat(32'h14, 4'b0010, 1'b0, 32'h0, 1'b1);
    push_rsp(32'h000000CC, 1'b0);
    issue(1'b0, 32'h15, 2'd0, 32'h0);
    push_beat(32'h10, 4'b1100, 1'b0, 32'h0, 1'b1);
    push_rsp(32'h00004433, 1'b0);
    issue(1'b0, 32'h12, 2'd1, 32'h0);

`ifdef TCB_SPLIT_CNT_EN
    cnt_exp = 32'd4; cnt_chk = 1'b1;
    @(posedge clk); #1;
    cnt_chk = 1'b0;
`endif

    // reset while in BEAT2: beat2 never issued, no upstream response
    push_beat(32'h10, 4'b1000, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h13, 2'd2, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef TCB_SPLIT_CNT_EN
    cnt_exp = 32'd5; cnt_chk = 1'b1;
`endif
    @(posedge clk); #1;
    rst = 1'b0; sub_vld = 1'b0;
`ifdef TCB_SPLIT_CNT_EN
    cnt_exp = 32'd0;
`endif
    @(posedge clk); #1;
`ifdef TCB_SPLIT_CNT_EN
    cnt_chk = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;
    // IDLE again: aligned read accepted in a single beat (BB CC DD EE)
    push_beat(32'h14, 4'b1111, 1'b0, 32'h0, 1'b1);
    push_rsp(32'hEEDDCCBB, 1'b0);
    issue(1'b0, 32'h14, 2'd2, 32'h0);

    repeat (4) @(posedge clk); #1;
    done = 1'b1;
  end

endmodule
`default_nettype wire
